// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light sensor conditioning block:
// occupancy FSM encoding and a counter-width helper.
package tl_pkg;

    // 2'b11 is unused; the FSM recovers from it to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OCC  = 2'b01,
        ST_HOLD = 2'b10
    } tl_state_e;

    // Ceiling log2: number of bits needed to hold values 0..v-1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Counter width that is never zero, so a 1-cycle parameter still yields a legal vector.
    function automatic int cw(input int v);
        return (clog2(v) < 1) ? 1 : clog2(v);
    endfunction

endpackage

// File: rtl/tl_sensor_ch.sv
// One road-sensor channel: 2-FF synchronizer, debounce filter, occupancy FSM
// with post-departure hold, arrival pulse and sticky stuck-high fault.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no car; waiting for the debounced sensor to rise
// OCC     | car present; stuck timer runs while the sensor stays high
// HOLD    | sensor fell; occupancy held for HOLD_CYCLES before IDLE
module tl_sensor_ch
    import tl_pkg::*;
#(
    parameter int DB_CYCLES    = 4,
    parameter int HOLD_CYCLES  = 8,
    parameter int STUCK_CYCLES = 255
) (
    input  logic clk,
    input  logic reset_n,   // active-high synchronous reset
    input  logic raw_i,
    output logic occ_o,
    output logic evt_o,
    output logic fault_o
);

    localparam int DW = cw(DB_CYCLES);
    localparam int HW = cw(HOLD_CYCLES);
    localparam int SW = cw(STUCK_CYCLES + 1);

    localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);
    localparam logic [SW-1:0] STUCK_LIM = SW'(STUCK_CYCLES - 1);
    localparam logic [SW-1:0] STUCK_SAT = SW'(STUCK_CYCLES);

    logic            s1_q, s2_q;
    logic            db_q, db_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    tl_state_e       state_q;
    logic [HW-1:0]   hcnt_q;
    logic [SW-1:0]   scnt_q;
    logic            evt_q, fault_q;

    // Debounce next-state: accept a new level only after DB_CYCLES stable differing samples.
    always_comb begin
        db_d   = db_q;
        dcnt_d = '0;
        if (s2_q != db_q) begin
            if (dcnt_q == DB_LAST) begin
                db_d   = s2_q;
                dcnt_d = '0;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end
    end

    // Synchronizer and debounce registers.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            db_q   <= 1'b0;
            dcnt_q <= '0;
        end else begin
            s1_q   <= raw_i;
            s2_q   <= s1_q;
            db_q   <= db_d;
            dcnt_q <= dcnt_d;
        end
    end

    // Occupancy FSM with hold timer, stuck timer, arrival pulse and sticky fault.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q <= ST_IDLE;
            hcnt_q  <= '0;
            scnt_q  <= '0;
            evt_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            evt_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (db_q) begin
                        state_q <= ST_OCC;
                        scnt_q  <= '0;
                        evt_q   <= 1'b1;
                    end
                end
                ST_OCC: begin
                    if (!db_q) begin
                        state_q <= ST_HOLD;
                        hcnt_q  <= HOLD_INIT;
                        scnt_q  <= '0;
                    end else begin
                        if (scnt_q != STUCK_SAT) scnt_q <= scnt_q + 1'b1;
                        if (scnt_q == STUCK_LIM) fault_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    // A returning sensor is treated as the same car or platoon: no new event.
                    if (db_q) begin
                        state_q <= ST_OCC;
                    end else if (hcnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        hcnt_q <= hcnt_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // A faulty channel is reported occupied so its road keeps being served.
    assign occ_o   = (state_q != ST_IDLE) | fault_q;
    assign evt_o   = evt_q;
    assign fault_o = fault_q;

endmodule

// File: rtl/tl_sensor_cond.sv
// Sensor conditioning front end for the traffic-light controller.
// Two independent channels turn raw road sensors A and B into clean Ta/Tb levels.
module tl_sensor_cond
    import tl_pkg::*;
#(
    parameter int DB_CYCLES    = 4,
    parameter int HOLD_CYCLES  = 8,
    parameter int STUCK_CYCLES = 255
) (
    input  logic clk,
    input  logic reset_n,   // active-high synchronous reset
    input  logic sa_raw,
    input  logic sb_raw,
    output logic Ta,
    output logic Tb,
    output logic a_evt,
    output logic b_evt,
    output logic a_fault,
    output logic b_fault
);

    tl_sensor_ch #(
        .DB_CYCLES   (DB_CYCLES),
        .HOLD_CYCLES (HOLD_CYCLES),
        .STUCK_CYCLES(STUCK_CYCLES)
    ) u_ch_a (
        .clk    (clk),
        .reset_n(reset_n),
        .raw_i  (sa_raw),
        .occ_o  (Ta),
        .evt_o  (a_evt),
        .fault_o(a_fault)
    );

    tl_sensor_ch #(
        .DB_CYCLES   (DB_CYCLES),
        .HOLD_CYCLES (HOLD_CYCLES),
        .STUCK_CYCLES(STUCK_CYCLES)
    ) u_ch_b (
        .clk    (clk),
        .reset_n(reset_n),
        .raw_i  (sb_raw),
        .occ_o  (Tb),
        .evt_o  (b_evt),
        .fault_o(b_fault)
    );

endmodule

// File: tb/tb_tl_sensor_cond.sv
// Self-checking bench for tl_sensor_cond: directed vector table, hand-written
// fault/reset sequences, and randomized traffic against a behavioural model.
module tb_tl_sensor_cond;

    localparam int DB    = 4;
    localparam int HOLD  = 8;
    localparam int STUCK = 255;

    logic clk = 1'b0;
    logic reset_n, sa_raw, sb_raw;
    logic Ta, Tb, a_evt, b_evt, a_fault, b_fault;

    int checks = 0;
    int errors = 0;

    tl_sensor_cond #(.DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .STUCK_CYCLES(STUCK)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .sa_raw (sa_raw),
        .sb_raw (sb_raw),
        .Ta     (Ta),
        .Tb     (Tb),
        .a_evt  (a_evt),
        .b_evt  (b_evt),
        .a_fault(a_fault),
        .b_fault(b_fault)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model (per channel, plain integers) ----------------
    int m_s1[2], m_s2[2], m_db[2], m_run[2], m_hold[2], m_occrun[2];
    bit m_occ[2], m_evt[2], m_fault[2];

    task automatic model_step(input logic rst, input logic ra, input logic rb);
        logic raw [2];
        raw[0] = ra;
        raw[1] = rb;
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                m_s1[c] = 0; m_s2[c] = 0; m_db[c] = 0; m_run[c] = 0;
                m_hold[c] = 0; m_occrun[c] = 0;
                m_occ[c] = 0; m_evt[c] = 0; m_fault[c] = 0;
            end else begin
                int old_db = m_db[c];
                m_evt[c] = 0;
                // occupancy driven by the debounced level seen before this edge
                if (m_occ[c]) begin
                    if (old_db == 0) begin
                        m_occ[c] = 0; m_hold[c] = HOLD; m_occrun[c] = 0;
                    end else begin
                        m_occrun[c]++;
                        if (m_occrun[c] >= STUCK) m_fault[c] = 1;
                    end
                end else if (m_hold[c] > 0) begin
                    if (old_db != 0) begin
                        m_occ[c] = 1; m_hold[c] = 0; m_occrun[c] = 0;
                    end else begin
                        m_hold[c]--;
                    end
                end else if (old_db != 0) begin
                    m_occ[c] = 1; m_evt[c] = 1; m_occrun[c] = 0;
                end
                // debounce: new level accepted after DB consecutive differing samples
                if (m_s2[c] != m_db[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DB) begin
                        m_db[c] = m_s2[c]; m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
                m_s2[c] = m_s1[c];
                m_s1[c] = int'(raw[c]);
            end
        end
    endtask

    function automatic logic [5:0] model_exp();
        logic ta, tb;
        ta = m_occ[0] || (m_hold[0] > 0) || m_fault[0];
        tb = m_occ[1] || (m_hold[1] > 0) || m_fault[1];
        return {ta, tb, m_evt[0], m_evt[1], m_fault[0], m_fault[1]};
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_step(reset_n, sa_raw, sb_raw);
        #1;
    endtask

    task automatic check(input string name, input logic [5:0] exp);
        logic [5:0] got;
        got = {Ta, Tb, a_evt, b_evt, a_fault, b_fault};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {Ta,Tb,a_evt,b_evt,a_fault,b_fault}=%b expected %b at %0t",
                     name, got, exp, $time);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rst;
        logic       sa;
        logic       sb;
        int         n;       // edges to apply
        logic       every;   // check after every edge, else only after the last
        logic [5:0] exp;     // {Ta,Tb,a_evt,b_evt,a_fault,b_fault}
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic sa, input logic sb, input int n,
                       input logic every, input logic [5:0] exp);
        vec_t v;
        v.rst = rst; v.sa = sa; v.sb = sb; v.n = n; v.every = every; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        reset_n = 1'b1;
        sa_raw  = 1'b0;
        sb_raw  = 1'b0;

        // reset state
        add(1, 0, 0, 2, 1, 6'b000000);
        // A arrival: 0 through edge 6, Ta+a_evt after edge 7, pulse gone after edge 8
        add(0, 1, 0, 6, 1, 6'b000000);
        add(0, 1, 0, 1, 0, 6'b101000);
        add(0, 1, 0, 1, 0, 6'b100000);
        // A departure: Ta stays through edge 14, drops after edge 15
        add(0, 0, 0, 14, 1, 6'b100000);
        add(0, 0, 0, 1, 0, 6'b000000);
        // 3-cycle glitch: nothing asserts
        add(0, 1, 0, 3, 1, 6'b000000);
        add(0, 0, 0, 12, 1, 6'b000000);
        // 4-cycle pulse: accepted, arrival after edge 7, released after edge 19
        add(0, 1, 0, 4, 1, 6'b000000);
        add(0, 0, 0, 2, 1, 6'b000000);
        add(0, 0, 0, 1, 0, 6'b101000);
        add(0, 0, 0, 11, 1, 6'b100000);
        add(0, 0, 0, 1, 0, 6'b000000);
        // A occupied, short drop so db returns during HOLD: no drop, no second event
        add(0, 1, 0, 6, 1, 6'b000000);
        add(0, 1, 0, 1, 0, 6'b101000);
        add(0, 0, 0, 4, 1, 6'b100000);
        add(0, 1, 0, 20, 1, 6'b100000);
        add(0, 0, 0, 14, 1, 6'b100000);
        add(0, 0, 0, 1, 0, 6'b000000);
        // simultaneous arrival on A and B, then only B leaves
        add(0, 1, 1, 6, 1, 6'b000000);
        add(0, 1, 1, 1, 0, 6'b111100);
        add(0, 1, 1, 1, 0, 6'b110000);
        add(0, 1, 0, 14, 1, 6'b110000);
        add(0, 1, 0, 1, 0, 6'b100000);
        add(0, 0, 0, 14, 1, 6'b100000);
        add(0, 0, 0, 1, 0, 6'b000000);

        foreach (vecs[i]) begin
            reset_n = vecs[i].rst;
            sa_raw  = vecs[i].sa;
            sb_raw  = vecs[i].sb;
            for (int k = 0; k < vecs[i].n; k++) begin
                tick();
                if (vecs[i].every || k == vecs[i].n - 1)
                    check($sformatf("vec%0d_edge%0d", i, k + 1), vecs[i].exp);
            end
        end

        // ---- stuck sensor on B: fault after 255 cycles in OCC, sticky until reset ----
        reset_n = 1'b1; tick(); reset_n = 1'b0;
        sb_raw = 1'b1;
        repeat (261) tick();
        check("stuck_before", 6'b010000);
        tick();
        check("stuck_set", 6'b010001);
        sb_raw = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            check("stuck_sticky", 6'b010001);
        end
        reset_n = 1'b1; tick();
        check("stuck_reset", 6'b000000);
        reset_n = 1'b0;

        // ---- reset mid-HOLD (A) and mid-debounce (B), then full re-arrival ----
        sa_raw = 1'b1;
        repeat (6) tick();
        tick();
        check("r6_arrive", 6'b101000);
        sa_raw = 1'b0;
        repeat (7) tick();
        sb_raw = 1'b1;
        repeat (3) tick();
        check("r6_in_hold", 6'b100000);
        reset_n = 1'b1; sa_raw = 1'b1;
        tick();
        check("r6_reset", 6'b000000);
        reset_n = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("r6_rearm", 6'b000000);
        end
        tick();
        check("r6_rearrive", 6'b111100);
        tick();
        check("r6_pulse_end", 6'b110000);

        // ---- randomized traffic against the model ----
        reset_n = 1'b1; sa_raw = 1'b0; sb_raw = 1'b0;
        tick();
        check("rnd_reset", model_exp());
        reset_n = 1'b0;
        for (int p = 0; p < 80; p++) begin
            int n;
            reset_n = ($urandom_range(0, 39) == 0);
            sa_raw  = 1'($urandom_range(0, 1));
            sb_raw  = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 24);
            for (int k = 0; k < n; k++) begin
                tick();
                check("rnd", model_exp());
            end
        end
        // long A occupancy so the model also exercises the stuck path
        reset_n = 1'b0; sa_raw = 1'b1; sb_raw = 1'($urandom_range(0, 1));
        for (int k = 0; k < 300; k++) begin
            tick();
            check("rnd_long", model_exp());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
